peridot_i2c_slave_ctrl: RTL and testbench
=========================================

Name: peridot_i2c_slave_ctrl

Overview:
- Transaction controller for the PERIDOT I2C byte engine; sits between the engine and an Avalon-MM-style register master port.
- Decodes the 7-bit device address and R/W bit, loads the register pointer from the first write byte, and issues register writes and prefetched reads.
- Decides ACK/NACK for every byte and uses the engine's SCL-stretch handshake (ackwaitrequest) to hold the bus while register accesses complete.

Parameters:
DEVICE_ADDRESS, 7'h50, 7-bit I2C slave address this block answers to.

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous reset, active-low
condi_start  in  1  engine start/repeated-start pulse
condi_stop  in  1  engine stop pulse
done_byte  in  1  engine pulse: 8 bits shifted; engine now stretches SCL
done_ack  in  1  engine pulse: ACK bit clock finished
recieve_bytedata  in  8  byte received from master; valid on done_byte
recieve_ackdata  in  1  1 = ACK seen on the last ACK bit (stable before done_ack)
ackwaitrequest  out  1  1 = engine keeps SCL stretched after the byte
send_ackdata  out  1  1 = drive ACK (SDA low) in the ACK slot
send_bytedata  out  8  next byte to transmit
send_bytedatavalid  out  1  engine loads send_bytedata at the ACK-bit SCL fall
reg_address  out  8  register pointer
reg_write  out  1  write strobe; held until reg_waitrequest=0
reg_writedata  out  8  latched write byte
reg_read  out  1  read strobe; held until reg_waitrequest=0
reg_readdata  in  8  read data; valid when reg_read=1 and reg_waitrequest=0
reg_waitrequest  in  1  slave stall
busy  out  1  1 when the state is not S_IDLE or S_IGNORE

Behaviour:
- Reset (reset_n=0 at clk edge):
  - State S_IDLE; ptr=0; reg_read=reg_write=0.
  - ackwaitrequest=0; send_ackdata=0; send_bytedatavalid=0; send_bytedata=8'hFF; reg_writedata=0.
  - Reset mid-access drops strobes immediately.
- States and outputs. aw = ackwaitrequest, ak = send_ackdata, both decoded from registered state:
  - S_IDLE, S_IGNORE: aw=0, ak=0. The engine stretches after every byte, so unaddressed traffic is released with NACK.
  - S_ADDR, S_SUB, S_WDATA, S_RDATA: aw=1, so a stretch begun by done_byte is held until the state changes.
  - S_ACKW: aw=0, ak=1.
  - S_WRITE, S_READ: aw=1, ak=0.
  - S_RACK: aw=0; ak=first_rd.
- Transitions:
  - condi_start in any state except S_WRITE/S_READ -> S_ADDR, and clear the data-valid register.
  - condi_stop in the same states -> S_IDLE, and clear the data-valid register.
  - In S_WRITE/S_READ, start/stop are ignored. They cannot legally occur while SCL is stretched.
  - S_ADDR, on done_byte:
    - byte[7:1]!=DEVICE_ADDRESS -> S_IGNORE.
    - Address match with byte[0]=0 -> S_ACKW, clear sub_got.
    - Address match with byte[0]=1 -> S_READ, set first_rd=1.
  - S_ACKW, on done_ack: -> S_WDATA if sub_got, else -> S_SUB.
  - S_SUB, on done_byte: ptr<=byte, sub_got<=1 -> S_ACKW.
  - S_WDATA, on done_byte: reg_writedata<=byte -> S_WRITE.
  - S_WRITE: reg_write=1, reg_address=ptr. When reg_waitrequest=0: ptr<=ptr+1 (8'hFF wraps to 8'h00) -> S_ACKW.
  - S_READ: reg_read=1. When reg_waitrequest=0: send_bytedata<=reg_readdata, data-valid<=1 -> S_RACK.
  - S_RACK, on done_ack:
    - recieve_ackdata=1 -> S_RDATA, first_rd<=0.
    - Otherwise -> S_IGNORE, data-valid<=0.
  - S_RDATA, on done_byte: ptr<=ptr+1, data-valid<=0 -> S_READ (prefetch of the next byte).
- send_bytedatavalid = data-valid AND recieve_ackdata (combinational):
  - A master NACK suppresses loading of the prefetched byte; the engine then sends 8'hFF.
  - The address ACK makes recieve_ackdata=1 (the slave drives SDA low).
- After a NACKed read, ptr points at the untransmitted (already read) byte. A side-effecting register read is therefore repeated on the next read.
- reg_address=ptr at all times. The bus cycle starts the cycle after entry to S_WRITE/S_READ; that state has zero-wait latency of 1 cycle.
- The engine samples aw one cycle after done_byte. Registered decode satisfies this because the state changes on the done_byte edge.

Test Plan:
- Write 0xA0, 0x10, 0x5A, 0x3C, stop; waitrequest=0 -> writes (0x10,0x5A) and (0x11,0x3C); all ACKs (ak=1); end state S_IDLE.
- Write 0xA0, 0x20; repeated start, 0xA1; read 3 bytes from memory 0x20=0x11, 0x21=0x22, 0x22=0x33, master NACKs the 3rd -> SDA bytes 0x11 0x22 0x33; reads at 0x20..0x23; ptr=0x23; state S_IGNORE.
- Address 0xB0 followed by 2 bytes -> aw=0 and ak=0 for every stretch, no reg strobes, busy=0.
- Write to ptr 0xFF with 2 bytes -> writes to 0xFF then 0x00.
- reg_waitrequest held high 20 cycles during S_WRITE -> aw=1 and reg_write=1 stable throughout; ACK is released only after waitrequest falls.
- reset_n=0 during S_READ with waitrequest high -> next cycle reg_read=0, aw=0, send_bytedata=8'hFF, state S_IDLE.

Source files
------------

// File: rtl/peridot_i2c_slave_ctrl.sv
// I2C slave transaction controller: address decode, register pointer, register
// bus writes and prefetched reads, with SCL stretching through ackwaitrequest.
module peridot_i2c_slave_ctrl #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       condi_start,
    input  logic       condi_stop,
    input  logic       done_byte,
    input  logic       done_ack,
    input  logic [7:0] recieve_bytedata,
    input  logic       recieve_ackdata,
    output logic       ackwaitrequest,
    output logic       send_ackdata,
    output logic [7:0] send_bytedata,
    output logic       send_bytedatavalid,
    output logic [7:0] reg_address,
    output logic       reg_write,
    output logic [7:0] reg_writedata,
    output logic       reg_read,
    input  logic [7:0] reg_readdata,
    input  logic       reg_waitrequest,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_IGNORE,
        S_ADDR,
        S_SUB,
        S_ACKW,
        S_WDATA,
        S_WRITE,
        S_READ,
        S_RACK,
        S_RDATA
    } state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_ptr, w_ptr_next;
    logic       r_sub_got, w_sub_got_next;
    logic       r_first_rd, w_first_rd_next;
    logic       r_dvalid, w_dvalid_next;
    logic [7:0] r_send_byte, w_send_byte_next;
    logic [7:0] r_wdata, w_wdata_next;
    logic       w_bus_phase;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 8'h00;
            r_sub_got   <= 1'b0;
            r_first_rd  <= 1'b0;
            r_dvalid    <= 1'b0;
            r_send_byte <= 8'hFF;
            r_wdata     <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_sub_got   <= w_sub_got_next;
            r_first_rd  <= w_first_rd_next;
            r_dvalid    <= w_dvalid_next;
            r_send_byte <= w_send_byte_next;
            r_wdata     <= w_wdata_next;
        end
    end

    // Bus cycles run with SCL stretched, so bus conditions cannot occur there.
    assign w_bus_phase = (r_state == S_WRITE) || (r_state == S_READ);

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_sub_got_next   = r_sub_got;
        w_first_rd_next  = r_first_rd;
        w_dvalid_next    = r_dvalid;
        w_send_byte_next = r_send_byte;
        w_wdata_next     = r_wdata;

        if (!w_bus_phase && condi_start) begin
            w_state_next  = S_ADDR;
            w_dvalid_next = 1'b0;
        end else if (!w_bus_phase && condi_stop) begin
            w_state_next  = S_IDLE;
            w_dvalid_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_IGNORE: ;
                S_ADDR: begin
                    if (done_byte) begin
                        if (recieve_bytedata[7:1] != DEVICE_ADDRESS) begin
                            w_state_next = S_IGNORE;
                        end else if (!recieve_bytedata[0]) begin
                            w_state_next   = S_ACKW;
                            w_sub_got_next = 1'b0;
                        end else begin
                            w_state_next    = S_READ;
                            w_first_rd_next = 1'b1;
                        end
                    end
                end
                S_ACKW: begin
                    if (done_ack) w_state_next = r_sub_got ? S_WDATA : S_SUB;
                end
                S_SUB: begin
                    if (done_byte) begin
                        w_ptr_next     = recieve_bytedata;
                        w_sub_got_next = 1'b1;
                        w_state_next   = S_ACKW;
                    end
                end
                S_WDATA: begin
                    if (done_byte) begin
                        w_wdata_next = recieve_bytedata;
                        w_state_next = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!reg_waitrequest) begin
                        w_ptr_next   = r_ptr + 8'd1;
                        w_state_next = S_ACKW;
                    end
                end
                S_READ: begin
                    if (!reg_waitrequest) begin
                        w_send_byte_next = reg_readdata;
                        w_dvalid_next    = 1'b1;
                        w_state_next     = S_RACK;
                    end
                end
                S_RACK: begin
                    if (done_ack) begin
                        if (recieve_ackdata) begin
                            w_state_next    = S_RDATA;
                            w_first_rd_next = 1'b0;
                        end else begin
                            w_state_next  = S_IGNORE;
                            w_dvalid_next = 1'b0;
                        end
                    end
                end
                S_RDATA: begin
                    // Byte went out; prefetch the following register.
                    if (done_byte) begin
                        w_ptr_next    = r_ptr + 8'd1;
                        w_dvalid_next = 1'b0;
                        w_state_next  = S_READ;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ackwaitrequest = 1'b0;
        send_ackdata   = 1'b0;
        case (r_state)
            S_ADDR, S_SUB, S_WDATA, S_RDATA, S_WRITE, S_READ: ackwaitrequest = 1'b1;
            S_ACKW: send_ackdata = 1'b1;
            S_RACK: send_ackdata = r_first_rd;
            default: ;
        endcase
    end

    assign send_bytedata      = r_send_byte;
    assign send_bytedatavalid = r_dvalid & recieve_ackdata;
    assign reg_address        = r_ptr;
    assign reg_writedata      = r_wdata;
    assign reg_write          = (r_state == S_WRITE);
    assign reg_read           = (r_state == S_READ);
    assign busy               = (r_state != S_IDLE) && (r_state != S_IGNORE);

endmodule

// File: tb/tb_peridot_i2c_slave_ctrl.sv
// Scoreboard bench for peridot_i2c_slave_ctrl: a transaction-level model pushes
// expected register accesses and ACK-slot behaviour; a monitor compares them.
module tb_peridot_i2c_slave_ctrl;

    localparam logic [6:0] DEV   = 7'h50;
    localparam int         BOUND = 200;

    logic       clk = 1'b0;
    logic       reset_n, condi_start, condi_stop, done_byte, done_ack;
    logic [7:0] recieve_bytedata;
    logic       recieve_ackdata;
    logic       ackwaitrequest, send_ackdata, send_bytedatavalid;
    logic [7:0] send_bytedata, reg_address, reg_writedata, reg_readdata;
    logic       reg_write, reg_read, reg_waitrequest, busy;

    always #5 clk = ~clk;

    typedef struct {
        logic       ak;
        logic       chk_tx;
        logic [7:0] tx;
    } ack_t;

    ack_t        exp_ack[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  wbuf[$];
    logic [7:0]  bus_mem[256];
    logic [7:0]  mdl_mem[256];
    logic [7:0]  mdl_ptr;
    int          n_checks = 0;
    int          n_fail = 0;
    int          last_stretch, max_stretch;
    logic        force_wait = 1'b0;
    logic        rand_wait = 1'b0;

    assign reg_readdata = bus_mem[reg_address];

    peridot_i2c_slave_ctrl #(.DEVICE_ADDRESS(DEV)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .condi_start        (condi_start),
        .condi_stop         (condi_stop),
        .done_byte          (done_byte),
        .done_ack           (done_ack),
        .recieve_bytedata   (recieve_bytedata),
        .recieve_ackdata    (recieve_ackdata),
        .ackwaitrequest     (ackwaitrequest),
        .send_ackdata       (send_ackdata),
        .send_bytedata      (send_bytedata),
        .send_bytedatavalid (send_bytedatavalid),
        .reg_address        (reg_address),
        .reg_write          (reg_write),
        .reg_writedata      (reg_writedata),
        .reg_read           (reg_read),
        .reg_readdata       (reg_readdata),
        .reg_waitrequest    (reg_waitrequest),
        .busy               (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // Slave register responder: waitrequest changes 2ns after each rising edge.
    initial begin
        reg_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            reg_waitrequest = force_wait | (rand_wait & ($urandom_range(0, 2) == 0));
        end
    end

    // Monitor: pops expectations whenever the DUT completes a bus access or an ACK slot.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (reg_write === 1'b1 && reg_read === 1'b1) fail_now("both_strobes");
                if (reg_write === 1'b1 && reg_waitrequest === 1'b0) begin
                    if (exp_wr.size() == 0) fail_now("unexpected_write");
                    else begin
                        logic [15:0] e;
                        e = exp_wr.pop_front();
                        check("write_addr", 32'(reg_address), 32'(e[15:8]));
                        check("write_data", 32'(reg_writedata), 32'(e[7:0]));
                    end
                    bus_mem[reg_address] = reg_writedata;
                end
                if (reg_read === 1'b1 && reg_waitrequest === 1'b0) begin
                    if (exp_rd.size() == 0) fail_now("unexpected_read");
                    else check("read_addr", 32'(reg_address), 32'(exp_rd.pop_front()));
                end
                if (done_ack === 1'b1) begin
                    if (exp_ack.size() == 0) fail_now("unexpected_ack_slot");
                    else begin
                        ack_t a;
                        logic [7:0] tx;
                        a  = exp_ack.pop_front();
                        tx = (send_bytedatavalid === 1'b1) ? send_bytedata : 8'hFF;
                        check("ack_drive", 32'(send_ackdata), 32'(a.ak));
                        if (a.chk_tx) check("sda_byte", 32'(tx), 32'(a.tx));
                    end
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick(); condi_start = 1'b1;
        tick(); condi_start = 1'b0;
    endtask

    task automatic pulse_stop();
        tick(); condi_stop = 1'b1;
        tick(); condi_stop = 1'b0;
    endtask

    task automatic wait_release();
        last_stretch = 0;
        while (ackwaitrequest === 1'b1 && last_stretch < BOUND) begin
            tick();
            last_stretch++;
        end
        if (last_stretch >= BOUND) fail_now("stretch_timeout");
        if (last_stretch > max_stretch) max_stretch = last_stretch;
    endtask

    task automatic byte_xfer(input logic [7:0] b);
        tick(); recieve_bytedata = b; done_byte = 1'b1;
        tick(); done_byte = 1'b0;
        wait_release();
    endtask

    // Slave-driven slots see the slave's own SDA; master slots carry the master's choice.
    task automatic ack_slot(input bit master, input bit master_ack);
        tick();
        recieve_ackdata = master ? master_ack : send_ackdata;
        done_ack = 1'b1;
        tick(); done_ack = 1'b0;
    endtask

    task automatic wr_txn(input logic [7:0] ab, input bit do_stop);
        bit m;
        m = (ab[7:1] == DEV) && !ab[0];
        pulse_start();
        exp_ack.push_back('{m, 1'b0, 8'h00});
        byte_xfer(ab);
        ack_slot(1'b0, 1'b0);
        for (int i = 0; i < wbuf.size(); i++) begin
            if (m) begin
                if (i == 0) mdl_ptr = wbuf[i];
                else begin
                    exp_wr.push_back({mdl_ptr, wbuf[i]});
                    mdl_mem[mdl_ptr] = wbuf[i];
                    mdl_ptr = mdl_ptr + 8'd1;
                end
            end
            exp_ack.push_back('{m, 1'b0, 8'h00});
            byte_xfer(wbuf[i]);
            ack_slot(1'b0, 1'b0);
        end
        if (do_stop) pulse_stop();
    endtask

    // Master reads n bytes and NACKs the last; the slave prefetches one beyond.
    task automatic rd_txn(input logic [7:0] ab, input int n, input bit do_stop);
        bit m;
        logic [7:0] a;
        m = (ab[7:1] == DEV) && ab[0];
        pulse_start();
        if (!m) begin
            exp_ack.push_back('{1'b0, 1'b0, 8'h00});
            byte_xfer(ab);
            ack_slot(1'b0, 1'b0);
            pulse_stop();
            return;
        end
        for (int k = 0; k <= n; k++) begin
            a = mdl_ptr + 8'(k);
            exp_rd.push_back(a);
            exp_ack.push_back('{(k == 0), 1'b1, (k < n) ? mdl_mem[a] : 8'hFF});
        end
        mdl_ptr = mdl_ptr + 8'(n);
        byte_xfer(ab);
        ack_slot(1'b0, 1'b0);
        for (int k = 1; k <= n; k++) begin
            byte_xfer(8'hFF);
            ack_slot(1'b1, k < n);
        end
        if (do_stop) pulse_stop();
    endtask

    initial begin
        int stable;
        logic [7:0] v;
        reset_n = 1'b0; condi_start = 1'b0; condi_stop = 1'b0;
        done_byte = 1'b0; done_ack = 1'b0; recieve_bytedata = 8'h00; recieve_ackdata = 1'b0;
        max_stretch = 0;
        mdl_ptr = 8'h00;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            bus_mem[i] = v;
            mdl_mem[i] = v;
        end
        repeat (3) tick();
        check("rst_aw", 32'(ackwaitrequest), 0);
        check("rst_ak", 32'(send_ackdata), 0);
        check("rst_sbv", 32'(send_bytedatavalid), 0);
        check("rst_sbyte", 32'(send_bytedata), 32'hFF);
        check("rst_wr", 32'(reg_write), 0);
        check("rst_rd", 32'(reg_read), 0);
        check("rst_wdata", 32'(reg_writedata), 0);
        check("rst_addr", 32'(reg_address), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        tick();

        // Two writes with auto-increment, then stop.
        wbuf = '{8'h10, 8'h5A, 8'h3C};
        wr_txn(8'hA0, 1'b1);
        check("busy_after_stop", 32'(busy), 0);

        // Set pointer, repeated start, read three bytes, NACK the last.
        for (int i = 0; i < 3; i++) begin
            bus_mem[8'h20 + i] = 8'(8'h11 * (i + 1));
            mdl_mem[8'h20 + i] = 8'(8'h11 * (i + 1));
        end
        wbuf = '{8'h20};
        wr_txn(8'hA0, 1'b0);
        rd_txn(8'hA1, 3, 1'b0);
        check("busy_after_nack", 32'(busy), 0);
        pulse_stop();

        // Foreign address: no stretch, no ACK, no strobes.
        max_stretch = 0;
        wbuf = '{8'h12, 8'h34};
        wr_txn(8'hB0, 1'b0);
        check("ignore_no_stretch", 32'(max_stretch), 0);
        check("ignore_busy", 32'(busy), 0);
        pulse_stop();

        // Pointer wrap 0xFF -> 0x00.
        wbuf = '{8'hFF, 8'hA5, 8'h5A};
        wr_txn(8'hA0, 1'b1);

        // Long register stall during a write.
        pulse_start();
        exp_ack.push_back('{1'b1, 1'b0, 8'h00});
        byte_xfer(8'hA0);
        ack_slot(1'b0, 1'b0);
        exp_ack.push_back('{1'b1, 1'b0, 8'h00});
        mdl_ptr = 8'h40;
        byte_xfer(8'h40);
        ack_slot(1'b0, 1'b0);
        exp_wr.push_back(16'h4077);
        mdl_mem[8'h40] = 8'h77;
        mdl_ptr = 8'h41;
        exp_ack.push_back('{1'b1, 1'b0, 8'h00});
        force_wait = 1'b1;
        tick(); recieve_bytedata = 8'h77; done_byte = 1'b1;
        tick(); done_byte = 1'b0;
        stable = 0;
        repeat (20) begin
            if (ackwaitrequest === 1'b1 && reg_write === 1'b1 && send_ackdata === 1'b0 &&
                reg_address === 8'h40 && reg_writedata === 8'h77) stable++;
            tick();
        end
        check("stall_hold", 32'(stable), 20);
        force_wait = 1'b0;
        wait_release();
        check("stall_release_ak", 32'(send_ackdata), 1);
        ack_slot(1'b0, 1'b0);
        pulse_stop();

        // Reset while a read is stalled.
        pulse_start();
        force_wait = 1'b1;
        tick(); recieve_bytedata = 8'hA1; done_byte = 1'b1;
        tick(); done_byte = 1'b0;
        repeat (3) tick();
        check("rd_strobe_stalled", 32'(reg_read), 1);
        reset_n = 1'b0;
        tick();
        check("rstmid_rd", 32'(reg_read), 0);
        check("rstmid_aw", 32'(ackwaitrequest), 0);
        check("rstmid_sbyte", 32'(send_bytedata), 32'hFF);
        check("rstmid_busy", 32'(busy), 0);
        force_wait = 1'b0;
        reset_n = 1'b1;
        mdl_ptr = 8'h00;
        tick();

        // Randomised traffic with random register stalls.
        rand_wait = 1'b1;
        repeat (40) begin
            logic [6:0] a7;
            int n;
            a7 = ($urandom_range(0, 4) == 0) ? 7'($urandom) : DEV;
            if ($urandom_range(0, 1) == 0) begin
                n = $urandom_range(0, 4);
                wbuf.delete();
                for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
                wr_txn({a7, 1'b0}, 1'($urandom_range(0, 1)));
            end else begin
                rd_txn({a7, 1'b1}, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            end
        end
        pulse_stop();
        rand_wait = 1'b0;
        repeat (5) tick();

        check("left_writes", 32'(exp_wr.size()), 0);
        check("left_reads", 32'(exp_rd.size()), 0);
        check("left_acks", 32'(exp_ack.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
